// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu : load/store unit acting as initiator on the data-memory bus.
//
// Accepts one load/store at a time over req_valid/req_ready, runs the memory
// bus sequence (address, tri-state data, wr/rd strobes, mode) and returns a
// one-cycle response with data or an error.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               pipeline request (valid/ready, store, mode, signed,
//                       addr, wdata)
//   resp_*              one-cycle completion pulse with rdata / err
//   mem_add, mem_mode   registered address and access mode to memory
//   mem_data            bidirectional data bus (driven only while writing)
//   mem_wr, mem_rd      write / read strobes (never high together)
//   mem_rd_st           memory read-status, looked at only in RD_WAIT
//   dbg_state           current FSM state encoding, for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE (and not during reset);
// the requester holds req_valid and the request fields stable until then.
// Requests presented while busy are not latched.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned word/halfword accesses are rejected from IDLE with
//               err=1 and no bus activity.
//   undefined : misaligned accesses go to memory unchanged.
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_mode,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_add,
  inout  wire  [WIDTH-1:0] mem_data,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [1:0]       mem_mode,
  input  logic             mem_rd_st,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_ASSERT = 3'd4,
    RD_WAIT   = 3'd5,
    RESP      = 3'd6
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]       mode_q, mode_d;
  logic             signed_q, signed_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             misalign;
  logic             drive_data;
  logic [WIDTH-1:0] rd_ext;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((req_mode == 2'd0) && (req_addr[1:0] != 2'b00)) ||
                    ((req_mode == 2'd1) && req_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  // Extension of the captured read data, using the latched mode/sign.
  always_comb begin
    rd_ext = mem_data;
    case (mode_q)
      2'd1:    rd_ext = {{(WIDTH-16){signed_q & mem_data[15]}}, mem_data[15:0]};
      2'd2:    rd_ext = {{(WIDTH-8){signed_q & mem_data[7]}}, mem_data[7:0]};
      default: rd_ext = mem_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mode_d   = mode_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          if ((req_mode == 2'd3) || misalign) begin
            // Rejected without touching the bus: address/mode keep old values.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            mode_d   = req_mode;
            signed_d = req_signed;
            state_d  = req_store ? WR_SETUP : RD_ASSERT;
          end
        end
      end
      WR_SETUP:  state_d = WR_PULSE;
      WR_PULSE:  state_d = WR_HOLD;
      WR_HOLD:   state_d = RESP;
      RD_ASSERT: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rd_st) begin
          rdata_d = rd_ext;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mode_q   <= mode_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // All outputs decode directly from registered state, so they are glitch-free
  // relative to the state register and drop on the same edge as a reset.
  assign drive_data = (state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                      (state_q == WR_HOLD);
  assign mem_data   = drive_data ? wdata_q : {WIDTH{1'bz}};
  assign mem_wr     = (state_q == WR_PULSE);
  assign mem_rd     = (state_q == RD_ASSERT) || (state_q == RD_WAIT);
  assign mem_add    = addr_q;
  assign mem_mode   = mode_q;
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q) ? rdata_q : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_store = 1'b0;
  logic [1:0]   req_mode = 2'd0;
  logic         req_signed = 1'b0;
  logic [W-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic         resp_err;
  logic [W-1:0] mem_add;
  wire  [W-1:0] mem_data;
  logic         mem_wr;
  logic         mem_rd;
  logic [1:0]   mem_mode;
  logic         mem_rd_st;
  logic [2:0]   dbg_state;

  dmem_lsu #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_mode(req_mode), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_add(mem_add), .mem_data(mem_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_mode(mem_mode), .mem_rd_st(mem_rd_st), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model (big-endian bytes) ----------------
  logic [7:0]   mem [0:63];
  logic [W-1:0] rd_val;
  logic         rd_st_en = 1'b1;
  logic [5:0]   ma;

  assign ma = mem_add[5:0];

  always_comb begin
    rd_val = '0;
    case (mem_mode)
      2'd1:    rd_val = {16'h0, mem[ma], mem[ma + 6'd1]};
      2'd2:    rd_val = {24'h0, mem[ma]};
      default: rd_val = {mem[ma], mem[ma + 6'd1], mem[ma + 6'd2], mem[ma + 6'd3]};
    endcase
  end

  assign mem_data  = mem_rd ? rd_val : {W{1'bz}};
  assign mem_rd_st = mem_rd & rd_st_en;

  always @(posedge mem_wr) begin
    case (mem_mode)
      2'd1: begin
        mem[ma]        = mem_data[15:8];
        mem[ma + 6'd1] = mem_data[7:0];
      end
      2'd2: mem[ma] = mem_data[7:0];
      default: begin
        mem[ma]        = mem_data[31:24];
        mem[ma + 6'd1] = mem_data[23:16];
        mem[ma + 6'd2] = mem_data[15:8];
        mem[ma + 6'd3] = mem_data[7:0];
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int overlap_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(negedge clk) if (mem_wr && mem_rd) overlap_cnt++;

  // Bus value with an undriven bus read as zero.
  function automatic logic [W-1:0] bus_val();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = (mem_data[i] === 1'b1);
    return v;
  endfunction

  // ---------------- driver ----------------
  int           r_lat, r_wr_cnt, r_wr_at, r_rd_cnt, r_drv_cnt, r_busy_rdy, r_addr_bad;
  logic [W-1:0] r_rdata;
  logic         r_err;

  task automatic do_req(input logic st, input logic [1:0] md, input logic sg,
                        input logic [W-1:0] ad, input logic [W-1:0] wd);
    int n;
    logic [W-1:0] mask;
    logic got_resp;
    mask = (md == 2'd2) ? 32'h0000_00FF : (md == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_wait_timeout", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_mode = md; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk);
    r_lat = 0; r_wr_cnt = 0; r_wr_at = 0; r_rd_cnt = 0; r_drv_cnt = 0;
    r_busy_rdy = 0; r_addr_bad = 0; r_rdata = 'x; r_err = 1'bx;
    got_resp = 1'b0;
    while (!got_resp && r_lat < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      r_lat++;
      if (mem_wr) begin r_wr_cnt++; if (r_wr_at == 0) r_wr_at = r_lat; end
      if (mem_rd) r_rd_cnt++;
      if (st && ((bus_val() & mask) == (wd & mask))) r_drv_cnt++;
      if (req_ready) r_busy_rdy++;
      if ((mem_wr || mem_rd) && mem_add != ad) r_addr_bad++;
      if (resp_valid) begin
        got_resp = 1'b1; r_rdata = resp_rdata; r_err = resp_err;
      end
    end
    if (!got_resp) check("resp_wait_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);

    // reset
    repeat (2) @(negedge clk);
    check("rst_req_ready",  {31'b0, req_ready},  32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_wr_rd",  {30'b0, mem_wr, mem_rd}, 32'd0);
    check("rst_mem_add",    mem_add, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_bus",        bus_val(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // store word
    do_req(1'b1, 2'd0, 1'b0, 32'h4, 32'hDEAD_BEEF);
    check("sw_lat", r_lat, 32'd4);
    check("sw_err", {31'b0, r_err}, 32'd0);
    check("sw_rdata", r_rdata, 32'd0);
    check("sw_wr_cnt", r_wr_cnt, 32'd1);
    check("sw_wr_at", r_wr_at, 32'd2);
    check("sw_drv_cnt", r_drv_cnt, 32'd3);
    check("sw_rd_cnt", r_rd_cnt, 32'd0);
    check("sw_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEAD_BEEF);
    check("sw_busy_ready", r_busy_rdy, 32'd0);
    check("sw_addr", r_addr_bad, 32'd0);

    // load word back
    exp_q.push_back(32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
    check("lw_lat", r_lat, 32'd3);
    check("lw_rdata", r_rdata, exp_q.pop_front());
    check("lw_err", {31'b0, r_err}, 32'd0);
    check("lw_rd_cnt", r_rd_cnt, 32'd2);
    check("lw_wr_cnt", r_wr_cnt, 32'd0);
    @(negedge clk);
    check("lw_bus_released", bus_val(), 32'd0);

    // byte store/loads
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h1234_5680);
    check("sb_mem8", {24'b0, mem[8]}, 32'h80);
    check("sb_mem9", {24'b0, mem[9]}, 32'h09);
    exp_q.push_back(32'hFFFF_FF80);
    do_req(1'b0, 2'd2, 1'b1, 32'h8, 32'h0);
    check("lb_signed", r_rdata, exp_q.pop_front());
    exp_q.push_back(32'h0000_0080);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    check("lb_unsigned", r_rdata, exp_q.pop_front());

    // halfword store/loads
    do_req(1'b1, 2'd1, 1'b0, 32'hC, 32'hAAAA_8001);
    check("sh_mem", {16'b0, mem[12], mem[13]}, 32'h8001);
    check("sh_mem14", {24'b0, mem[14]}, 32'h0E);
    exp_q.push_back(32'hFFFF_8001);
    do_req(1'b0, 2'd1, 1'b1, 32'hC, 32'h0);
    check("lh_signed", r_rdata, exp_q.pop_front());
    exp_q.push_back(32'h0000_8001);
    do_req(1'b0, 2'd1, 1'b0, 32'hC, 32'h0);
    check("lh_unsigned", r_rdata, exp_q.pop_front());

    // read timeout: RD_ASSERT + 8 RD_WAIT cycles, response one cycle later
    rd_st_en = 1'b0;
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    rd_st_en = 1'b1;
    check("to_lat", r_lat, 32'd10);
    check("to_rd_cnt", r_rd_cnt, 32'd9);
    check("to_err", {31'b0, r_err}, 32'd1);
    check("to_rdata", r_rdata, 32'd0);

    // illegal mode
    do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h5555_5555);
    check("ill_st_lat", r_lat, 32'd1);
    check("ill_st_err", {31'b0, r_err}, 32'd1);
    check("ill_st_strobes", r_wr_cnt + r_rd_cnt, 32'd0);
    check("ill_st_mem", {mem[32], mem[33], mem[34], mem[35]}, 32'h2021_2223);
    do_req(1'b0, 2'd3, 1'b1, 32'h4, 32'h0);
    check("ill_ld_err", {31'b0, r_err}, 32'd1);
    check("ill_ld_rdata", r_rdata, 32'd0);
    check("ill_ld_strobes", r_wr_cnt + r_rd_cnt, 32'd0);

    // misaligned word load at 0x2
    do_req(1'b0, 2'd0, 1'b0, 32'h2, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_lat", r_lat, 32'd1);
    check("mis_err", {31'b0, r_err}, 32'd1);
    check("mis_rd_cnt", r_rd_cnt, 32'd0);
`else
    check("mis_lat", r_lat, 32'd3);
    check("mis_err", {31'b0, r_err}, 32'd0);
    check("mis_rdata", r_rdata, 32'h0203_DEAD);
`endif

    // reset during WR_PULSE
    begin
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_mode = 2'd0; req_signed = 1'b0;
      req_addr = 32'h14; req_wdata = 32'h1122_3344;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_wr && n < 10) begin @(negedge clk); n++; end
      check("rr_saw_wr", {31'b0, mem_wr}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rr_mem_wr", {31'b0, mem_wr}, 32'd0);
      check("rr_bus", bus_val(), 32'd0);
      check("rr_resp_valid", {31'b0, resp_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rr_ready", {31'b0, req_ready}, 32'd1);
      n = 0;
      repeat (5) begin @(negedge clk); if (resp_valid) n++; end
      check("rr_no_resp", n, 32'd0);
    end

    check("strobe_overlap", overlap_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit that acts as the initiator on the data-memory bus. It accepts one load or store request at a time from the pipeline over a valid/ready handshake and drives the memory-side signals: address, bidirectional data, wr/rd strobes and access mode. It waits for the read-status handshake on loads, then returns data or an error to the pipeline. It sits between the EX/MEM stage and the data memory.

Parameters:
WIDTH, 32, address and data width in bits.
TIMEOUT, 8, maximum number of RD_WAIT cycles before a load is aborted with an error (≥1).

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  1  pipeline request present.
req_ready  output  1  unit can accept a request.
req_store  input  1  1 = store, 0 = load.
req_mode  input  2  0 = word, 1 = halfword, 2 = byte, 3 = illegal.
req_signed  input  1  sign-extend a halfword or byte load.
req_addr  input  WIDTH  byte address.
req_wdata  input  WIDTH  store data; halfword uses [15:0], byte uses [7:0].
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  WIDTH  load result; 0 for stores and errors.
resp_err  output  1  qualifies resp_valid: error.
mem_add  output  WIDTH  memory address.
mem_data  inout  WIDTH  memory data bus.
mem_wr  output  1  write strobe; memory writes on its rising edge.
mem_rd  output  1  read strobe; memory drives mem_data while it is high.
mem_mode  output  2  access mode to memory.
mem_rd_st  input  1  memory read-status; valid only while mem_rd is high.

Behaviour:
- Reset values: every output is 0, mem_data is high-Z, the state is IDLE, and resp_rdata is 0. Reset taken mid-operation drops mem_wr and mem_rd in the same edge and returns to IDLE with no response issued.
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ASSERT, RD_WAIT, RESP.
- IDLE:
  - req_ready is 1 only in IDLE.
  - On req_valid && req_ready, the unit latches addr, wdata, mode, store and signed.
  - An illegal mode (3) goes to RESP with err=1 and causes no bus activity.
  - Otherwise a store goes to WR_SETUP and a load goes to RD_ASSERT.
- mem_add and mem_mode are registered from the latched request and stay stable from the first bus state through RESP.
- Store sequence:
  - WR_SETUP: mem_data is driven and mem_wr=0.
  - WR_PULSE: mem_wr=1.
  - WR_HOLD: mem_wr=0 while mem_data is still driven.
  - RESP: mem_data is released to Z.
  - Latency: accept at cycle N gives resp_valid at N+4.
- Load sequence:
  - RD_ASSERT: mem_rd=1 and the timeout counter is cleared.
  - RD_WAIT: mem_rd=1. If mem_rd_st=1, the unit captures mem_data and goes to RESP. Otherwise the counter increments; when the counter reaches TIMEOUT-1 without mem_rd_st, the unit goes to RESP with err=1.
  - mem_rd_st is never sampled in RD_ASSERT.
  - RESP: mem_rd=0.
  - Minimum latency: accept at N gives resp_valid at N+3.
- Load extension of the captured data:
  - Word: unchanged.
  - Halfword: bits [15:0], zero-extended, or sign-extended from bit 15 if signed.
  - Byte: bits [7:0], zero-extended, or sign-extended from bit 7 if signed.
- Bus exclusion: mem_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. mem_wr and mem_rd are never high together.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is 0 during RESP, so a back-to-back request is accepted in the following IDLE cycle at the earliest.
- A req_valid arriving while the unit is busy is ignored (not latched). The requester must hold it until ready.

Optional Feature:
LSU_ALIGN_CHECK_EN:
- Defined: a word access with addr[1:0]≠0, or a halfword access with addr[0]≠0, goes from IDLE directly to RESP with err=1 and causes no memory strobe.
- Undefined: misaligned accesses are issued to memory unchanged with err=0.

Test Plan:
- Store word: addr=0x4, wdata=0xDEADBEEF, mode=0 → one mem_wr pulse at N+2; mem_data=0xDEADBEEF during N+1..N+3; resp_valid at N+4 with err=0; memory bytes 4..7 = DE AD BE EF.
- Load after store: addr=0x4, mode=0 → mem_rd high N+1..N+2; resp_rdata=0xDEADBEEF at N+3; mem_data high-Z after the response.
- Byte load with sign: mem[8]=0x80, mode=2 → signed=1 gives 0xFFFFFF80; signed=0 gives 0x00000080. Halfword 0x8001 with signed=1 gives 0xFFFF8001.
- Timeout: hold mem_rd_st=0 with TIMEOUT=8 → mem_rd falls after 8 RD_WAIT cycles; resp_err=1 and resp_rdata=0.
- Illegal mode 3, and with LSU_ALIGN_CHECK_EN a word at addr=0x2 → resp_valid at N+1 with err=1; mem_wr and mem_rd stay 0.
- Assert rst in WR_PULSE → mem_wr=0 and mem_data=Z on the next edge; no resp_valid; req_ready=1 the cycle after reset is released.
